// File: rtl/ram_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_reader_if
// Brief    : Bundles the burst request, RAM initiator and output stream
//            signals of ram_burst_reader. The master modport is the reader;
//            the slave modport is its environment (RAM, requester and sink).
//            Optional checksum port is present when
//            RAM_BURST_READER_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
);
  // Burst request
  logic                  RAM_BURST_READER_Start;
  logic [ADDR_WIDTH-1:0] RAM_BURST_READER_Base_Addr;
  logic [LEN_WIDTH-1:0]  RAM_BURST_READER_Length;
  // RAM initiator side
  logic [ADDR_WIDTH-1:0] RAM_BURST_READER_Ram_Address;
  logic                  RAM_BURST_READER_Ram_We;
  logic                  RAM_BURST_READER_Ram_Oe;
  logic [DATA_WIDTH-1:0] RAM_BURST_READER_Ram_Data;
  // Output stream
  logic [DATA_WIDTH-1:0] RAM_BURST_READER_Out_Data;
  logic                  RAM_BURST_READER_Out_Valid;
  logic                  RAM_BURST_READER_Out_Ready;
  // Status
  logic                  RAM_BURST_READER_Busy;
  logic                  RAM_BURST_READER_Done;
`ifdef RAM_BURST_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] RAM_BURST_READER_Checksum;
`endif

  modport master (
    input  RAM_BURST_READER_Start,
    input  RAM_BURST_READER_Base_Addr,
    input  RAM_BURST_READER_Length,
    output RAM_BURST_READER_Ram_Address,
    output RAM_BURST_READER_Ram_We,
    output RAM_BURST_READER_Ram_Oe,
    input  RAM_BURST_READER_Ram_Data,
    output RAM_BURST_READER_Out_Data,
    output RAM_BURST_READER_Out_Valid,
    input  RAM_BURST_READER_Out_Ready,
    output RAM_BURST_READER_Busy,
`ifdef RAM_BURST_READER_CHECKSUM_EN
    output RAM_BURST_READER_Checksum,
`endif
    output RAM_BURST_READER_Done
  );

  modport slave (
    output RAM_BURST_READER_Start,
    output RAM_BURST_READER_Base_Addr,
    output RAM_BURST_READER_Length,
    input  RAM_BURST_READER_Ram_Address,
    input  RAM_BURST_READER_Ram_We,
    input  RAM_BURST_READER_Ram_Oe,
    output RAM_BURST_READER_Ram_Data,
    input  RAM_BURST_READER_Out_Data,
    input  RAM_BURST_READER_Out_Valid,
    output RAM_BURST_READER_Out_Ready,
    input  RAM_BURST_READER_Busy,
`ifdef RAM_BURST_READER_CHECKSUM_EN
    input  RAM_BURST_READER_Checksum,
`endif
    input  RAM_BURST_READER_Done
  );
endinterface
`default_nettype wire

// File: rtl/ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_reader
// Brief    : Reads a contiguous burst of words from a single-port synchronous
//            RAM (one-cycle read latency) and streams them out on a
//            valid/ready interface through a 2-entry skid buffer.
//            Optional feature macro: RAM_BURST_READER_CHECKSUM_EN adds a
//            running modulo-2^DATA_WIDTH sum of the transferred words.
// Revision : 1.0 - initial release
// ============================================================================
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  wire logic             RAM_BURST_READER_Clk,
  input  wire logic             RAM_BURST_READER_Reset,
  ram_burst_reader_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0]  c_len_one  = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_done;
  logic                  w_done_nxt;

  logic [ADDR_WIDTH-1:0] r_next_addr;   // next address to issue
  logic [ADDR_WIDTH-1:0] r_last_addr;   // last address issued (held on bus)
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issued;
  logic [LEN_WIDTH-1:0]  r_delivered;
  logic                  r_inflight;    // a read was issued last cycle

  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;

  logic                  w_start_ok;
  logic                  w_xfer;
  logic [1:0]            w_occ_after;
  logic                  w_issue;
  logic                  w_last_issue;
  logic                  w_last_xfer;

  assign w_start_ok  = (r_state == S_IDLE) && bus.RAM_BURST_READER_Start;
  assign w_xfer      = (r_count != 2'd0) && bus.RAM_BURST_READER_Out_Ready;

  // Occupancy the buffer will have once this cycle's transfer and the
  // pending capture settle; issuing against it keeps the buffer from
  // overflowing while still sustaining one word per cycle under full Ready.
  assign w_occ_after = r_count + {1'b0, r_inflight} - {1'b0, w_xfer};
  assign w_issue     = (r_state == S_READ) && (r_issued != r_len) &&
                       (w_occ_after < 2'd2);
  assign w_last_issue = w_issue && (r_issued == (r_len - c_len_one));
  assign w_last_xfer  = w_xfer && (r_delivered == (r_len - c_len_one));

  // State and Done pulse registers
  always_ff @(posedge RAM_BURST_READER_Clk) begin
    if (RAM_BURST_READER_Reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic and Done generation
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.RAM_BURST_READER_Start) begin
          if (bus.RAM_BURST_READER_Length != '0) begin
            w_state_nxt = S_READ;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_READ: begin
        if (w_last_issue) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_xfer) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Address generation, counters, read capture and skid buffer
  always_ff @(posedge RAM_BURST_READER_Clk) begin
    if (RAM_BURST_READER_Reset) begin
      r_next_addr <= '0;
      r_last_addr <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_inflight  <= 1'b0;
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      if (w_start_ok && (bus.RAM_BURST_READER_Length != '0)) begin
        r_next_addr <= bus.RAM_BURST_READER_Base_Addr;
        r_len       <= bus.RAM_BURST_READER_Length;
        r_issued    <= '0;
        r_delivered <= '0;
      end
      if (w_issue) begin
        r_last_addr <= r_next_addr;
        r_next_addr <= r_next_addr + c_addr_one;
        r_issued    <= r_issued + c_len_one;
      end
      r_inflight <= w_issue;
      if (r_inflight) begin
        if (r_wr_ptr) begin
          r_buf1 <= bus.RAM_BURST_READER_Ram_Data;
        end else begin
          r_buf0 <= bus.RAM_BURST_READER_Ram_Data;
        end
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_xfer) begin
        r_rd_ptr    <= ~r_rd_ptr;
        r_delivered <= r_delivered + c_len_one;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_xfer};
    end
  end

`ifdef RAM_BURST_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  // Running sum of transferred words, restarted by each accepted Start
  always_ff @(posedge RAM_BURST_READER_Clk) begin
    if (RAM_BURST_READER_Reset) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum + bus.RAM_BURST_READER_Out_Data;
    end
  end

  assign bus.RAM_BURST_READER_Checksum = r_checksum;
`endif

  // The RAM sees the address being issued this cycle, otherwise the last one
  assign bus.RAM_BURST_READER_Ram_Address = w_issue ? r_next_addr : r_last_addr;
  assign bus.RAM_BURST_READER_Ram_We      = 1'b0;
  assign bus.RAM_BURST_READER_Ram_Oe      = (r_state != S_IDLE);
  assign bus.RAM_BURST_READER_Busy        = (r_state != S_IDLE);
  assign bus.RAM_BURST_READER_Done        = r_done;
  assign bus.RAM_BURST_READER_Out_Valid   = (r_count != 2'd0);
  assign bus.RAM_BURST_READER_Out_Data    = r_rd_ptr ? r_buf1 : r_buf0;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_burst_reader
// Brief    : Self-checking bench for ram_burst_reader. A behavioural RAM
//            (mem[i] = i) feeds the reader; expected words are derived from
//            the base address, length and memory contents. Define
//            RAM_BURST_READER_CHECKSUM_EN to also check the checksum port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_burst_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] mem [0:1023];

  always #5 clk = ~clk;

  ram_burst_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .LEN_WIDTH(11)) bus ();

  ram_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .LEN_WIDTH(11)) dut (
    .RAM_BURST_READER_Clk   (clk),
    .RAM_BURST_READER_Reset (rst),
    .bus                    (bus)
  );

  // Synchronous RAM: data appears one cycle after the address, tri-stated
  // while output enable is low
  always @(posedge clk) begin
    bus.RAM_BURST_READER_Ram_Data <= bus.RAM_BURST_READER_Ram_Oe ?
                                     mem[bus.RAM_BURST_READER_Ram_Address] : 8'hzz;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit next_ready(input int mode, input int j);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (j % 3) == 0;
    return 1'($urandom % 2);
  endfunction

  // One burst; mode 0 = Ready held high, 1 = Ready 1,0,0,..., 2 = random.
  // A nonzero poke pulses a stray Start at that cycle, which must be ignored.
  task automatic run_burst(input int base, input int len, input int mode, input int poke);
    logic [7:0] expq [$];
    logic [7:0] held;
    logic [7:0] sum;
    bit         stalled;
    int         j, done_n, done_j, busy_n, limit;
    sum = 8'h00;
    for (int k = 0; k < len; k++) begin
      expq.push_back(mem[(base + k) % 1024]);
      sum = sum + mem[(base + k) % 1024];
    end
    stalled = 1'b0; held = 8'h00;
    done_n = 0; done_j = -1; busy_n = 0; j = 0;
    limit = len * 8 + 20;
    @(negedge clk);
    bus.RAM_BURST_READER_Start     = 1'b1;
    bus.RAM_BURST_READER_Base_Addr = base[9:0];
    bus.RAM_BURST_READER_Length    = len[10:0];
    bus.RAM_BURST_READER_Out_Ready = next_ready(mode, 0);
    while (done_n == 0 && j < limit) begin
      @(negedge clk);
      j++;
      bus.RAM_BURST_READER_Start = (j == poke);
      if (j == poke) begin
        bus.RAM_BURST_READER_Base_Addr = 10'($urandom);
        bus.RAM_BURST_READER_Length    = 11'd3;
      end
      bus.RAM_BURST_READER_Out_Ready = next_ready(mode, j);
      chk("oe_follows_busy", bus.RAM_BURST_READER_Ram_Oe, bus.RAM_BURST_READER_Busy);
      chk("we_low", bus.RAM_BURST_READER_Ram_We, 0);
      if (bus.RAM_BURST_READER_Busy) busy_n++;
      if (stalled) chk("stall_stable", bus.RAM_BURST_READER_Out_Data, held);
      if (bus.RAM_BURST_READER_Out_Valid && bus.RAM_BURST_READER_Out_Ready) begin
        if (expq.size() == 0) chk("extra_word", 1, 0);
        else chk("data", bus.RAM_BURST_READER_Out_Data, expq.pop_front());
      end
      stalled = bus.RAM_BURST_READER_Out_Valid && !bus.RAM_BURST_READER_Out_Ready;
      held    = bus.RAM_BURST_READER_Out_Data;
      if (mode == 0 && j <= len)
        chk("addr", bus.RAM_BURST_READER_Ram_Address, (base + j - 1) % 1024);
      if (bus.RAM_BURST_READER_Done) begin
        done_n++;
        done_j = j;
`ifdef RAM_BURST_READER_CHECKSUM_EN
        chk("checksum", bus.RAM_BURST_READER_Checksum, sum);
`endif
      end
    end
    bus.RAM_BURST_READER_Start = 1'b0;
    chk("done_seen", done_n, 1);
    chk("words_left", expq.size(), 0);
    if (mode == 0) begin
      chk("busy_cycles", busy_n, len + 2);
      chk("done_latency", done_j, len + 3);
    end
    @(negedge clk);
    chk("done_single", bus.RAM_BURST_READER_Done, 0);
    chk("idle_after", bus.RAM_BURST_READER_Busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
    bus.RAM_BURST_READER_Start     = 1'b0;
    bus.RAM_BURST_READER_Base_Addr = '0;
    bus.RAM_BURST_READER_Length    = '0;
    bus.RAM_BURST_READER_Out_Ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_addr",  bus.RAM_BURST_READER_Ram_Address, 0);
    chk("rst_oe",    bus.RAM_BURST_READER_Ram_Oe, 0);
    chk("rst_valid", bus.RAM_BURST_READER_Out_Valid, 0);
    chk("rst_data",  bus.RAM_BURST_READER_Out_Data, 0);
    chk("rst_busy",  bus.RAM_BURST_READER_Busy, 0);
    chk("rst_done",  bus.RAM_BURST_READER_Done, 0);
`ifdef RAM_BURST_READER_CHECKSUM_EN
    chk("rst_checksum", bus.RAM_BURST_READER_Checksum, 0);
`endif

    // Basic burst, address wrap, stalled stream
    run_burst(32'h10, 4, 0, 0);
    run_burst(32'h3FE, 4, 0, 0);
    run_burst(32'h40, 8, 1, 0);

    // Zero-length request
    @(negedge clk);
    bus.RAM_BURST_READER_Start  = 1'b1;
    bus.RAM_BURST_READER_Length = 11'd0;
    @(negedge clk);
    bus.RAM_BURST_READER_Start  = 1'b0;
    chk("len0_done",  bus.RAM_BURST_READER_Done, 1);
    chk("len0_oe",    bus.RAM_BURST_READER_Ram_Oe, 0);
    chk("len0_valid", bus.RAM_BURST_READER_Out_Valid, 0);
    chk("len0_busy",  bus.RAM_BURST_READER_Busy, 0);
    @(negedge clk);
    chk("len0_done_end", bus.RAM_BURST_READER_Done, 0);
    chk("len0_valid_end", bus.RAM_BURST_READER_Out_Valid, 0);

    // Reset in the middle of an 8-word burst after 3 words delivered
    @(negedge clk);
    bus.RAM_BURST_READER_Start     = 1'b1;
    bus.RAM_BURST_READER_Base_Addr = 10'h20;
    bus.RAM_BURST_READER_Length    = 11'd8;
    bus.RAM_BURST_READER_Out_Ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      bus.RAM_BURST_READER_Start = 1'b0;
      if (j >= 3) chk("pre_rst_data", bus.RAM_BURST_READER_Out_Data, 8'h20 + j - 3);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", bus.RAM_BURST_READER_Out_Valid, 0);
    chk("abort_busy",  bus.RAM_BURST_READER_Busy, 0);
    chk("abort_oe",    bus.RAM_BURST_READER_Ram_Oe, 0);
    chk("abort_done",  bus.RAM_BURST_READER_Done, 0);
    @(negedge clk);
    chk("abort_done_late", bus.RAM_BURST_READER_Done, 0);
    run_burst(0, 2, 0, 0);

    // Stray Start while busy, and the checksum reference burst
    run_burst(32'hF0, 16, 0, 3);

    // Randomized bursts against the reference model
    for (int r = 0; r < 6; r++) begin
      run_burst(int'($urandom % 1024), int'($urandom_range(1, 20)), 2, int'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
